alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_if.sv | 33 +++
 rtl/alu_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_alu_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_if.sv
// Bundle of the request, operand and unit-handshake signals around alu_ctrl.
// The slave modport is the controller itself; the master modport is whatever
// surrounds it (requester plus the logic and arith units).
interface alu_ctrl_if;
    logic        start;
    logic [3:0]  opcode;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        log_cs;
    logic        ari_cs;
    logic [1:0]  op_sub;
    logic        log_rdy;
    logic        ari_rdy;
    logic [15:0] log_out_d;
    logic [15:0] ari_out_d;
    logic [15:0] result;
    logic        zf;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, opcode, a_in, b_in, log_rdy, ari_rdy, log_out_d, ari_out_d,
        input  op_a, op_b, log_cs, ari_cs, op_sub, result, zf, busy, done, err
    );

    modport slave (
        input  start, opcode, a_in, b_in, log_rdy, ari_rdy, log_out_d, ari_out_d,
        output op_a, op_b, log_cs, ari_cs, op_sub, result, zf, busy, done, err
    );
endinterface

// File: rtl/alu_ctrl.sv
// Sequencer that hands one operation to either the logic or the arith unit,
// follows the unit's ready handshake (drop = accepted, rise = result valid),
// captures the result and reports done, or err on an illegal unit / timeout.
module alu_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic     clk,
    input  logic     rst,
    alu_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        DONE      = 3'd4,
        ERR       = 3'd5
    } state_t;

    localparam int             CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  WAIT_LAST = CW'(TIMEOUT - 1);

    // Only unit codes 0 (logic) and 1 (arith) exist.
    function automatic logic unit_legal(input logic [1:0] unit);
        logic ok;
        case (unit)
            2'b00:   ok = 1'b1;
            2'b01:   ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] wait_cnt_r;
    logic          wait_clr_s;
    logic          wait_inc_s;
    logic          capture_s;
    logic          unit_ari_r;
    logic [15:0]   op_a_r;
    logic [15:0]   op_b_r;
    logic [1:0]    op_sub_r;
    logic [15:0]   result_r;
    logic          zf_r;
    logic          log_cs_r;
    logic          ari_cs_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;
    logic          sel_rdy_s;
    logic [15:0]   sel_out_s;

    // Look only at the selected unit so the idle unit's X/Z never leaks in.
    always_comb begin
        sel_rdy_s = 1'b0;
        sel_out_s = 16'h0000;
        if (unit_ari_r) begin
            sel_rdy_s = bus.ari_rdy;
            sel_out_s = bus.ari_out_d;
        end else begin
            sel_rdy_s = bus.log_rdy;
            sel_out_s = bus.log_out_d;
        end
    end

    // Next-state decode plus wait-counter and capture controls.
    always_comb begin
        state_s    = state_r;
        wait_clr_s = 1'b0;
        wait_inc_s = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (unit_legal(bus.opcode[3:2])) begin
                        state_s = ISSUE;
                    end else begin
                        state_s = ERR;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s    = WAIT_ACK;
                wait_clr_s = 1'b1;
            end
            WAIT_ACK: begin
                if (!sel_rdy_s) begin
                    state_s    = WAIT_DONE;
                    wait_clr_s = 1'b1;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s = ERR;
                end else begin
                    wait_inc_s = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (sel_rdy_s) begin
                    state_s   = DONE;
                    capture_s = 1'b1;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s = ERR;
                end else begin
                    wait_inc_s = 1'b1;
                end
            end
            DONE:    state_s = IDLE;
            ERR:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Per-phase wait counter, cleared whenever a wait phase is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= '0;
        end else if (wait_clr_s) begin
            wait_cnt_r <= '0;
        end else if (wait_inc_s) begin
            wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Latch operands and opcode on an accepted start; held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_r     <= 16'h0000;
            op_b_r     <= 16'h0000;
            op_sub_r   <= 2'b00;
            unit_ari_r <= 1'b0;
        end else if ((state_r == IDLE) && bus.start) begin
            op_a_r     <= bus.a_in;
            op_b_r     <= bus.b_in;
            op_sub_r   <= bus.opcode[1:0];
            unit_ari_r <= bus.opcode[2];
        end else begin
            op_a_r     <= op_a_r;
            op_b_r     <= op_b_r;
            op_sub_r   <= op_sub_r;
            unit_ari_r <= unit_ari_r;
        end
    end

    // Result and zero flag change only on a successful completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= 16'h0000;
            zf_r     <= 1'b0;
        end else if (capture_s) begin
            result_r <= sel_out_s;
            zf_r     <= (sel_out_s == 16'h0000);
        end else begin
            result_r <= result_r;
            zf_r     <= zf_r;
        end
    end

    // Registered status and chip selects, derived from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_cs_r <= 1'b0;
            ari_cs_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if (state_s == ISSUE) begin
                log_cs_r <= (bus.opcode[3:2] == 2'b00);
                ari_cs_r <= (bus.opcode[3:2] == 2'b01);
            end else begin
                log_cs_r <= 1'b0;
                ari_cs_r <= 1'b0;
            end
            busy_r <= (state_s != IDLE);
            done_r <= (state_s == DONE);
            err_r  <= (state_s == ERR);
        end
    end

    assign bus.op_a   = op_a_r;
    assign bus.op_b   = op_b_r;
    assign bus.op_sub = op_sub_r;
    assign bus.result = result_r;
    assign bus.zf     = zf_r;
    assign bus.log_cs = log_cs_r;
    assign bus.ari_cs = ari_cs_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with simple behavioural logic/arith unit models.
module tb_alu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    // unit model modes: 0 = normal, 1 = stalled (rdy stuck high), 2 = junk (rdy X, data Z)
    int   log_mode = 0;
    int   ari_mode = 2;
    int   log_cnt = 0;
    int   ari_cnt = 0;

    alu_ctrl_if bus ();

    alu_ctrl #(.TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [15:0] log_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'd0:    return ~(a & b);
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [15:0] ari_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a + 16'h0001;
            default: return a - 16'h0001;
        endcase
    endfunction

    // Logic unit: rdy drops after cs, result valid for one cycle two cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            log_cnt <= 0; bus.log_rdy <= 1'b1; bus.log_out_d <= 16'hzzzz;
        end else if (log_mode == 1) begin
            log_cnt <= 0; bus.log_rdy <= 1'b1; bus.log_out_d <= 16'hzzzz;
        end else if (log_mode == 2) begin
            log_cnt <= 0; bus.log_rdy <= 1'bx; bus.log_out_d <= 16'hzzzz;
        end else if (bus.log_cs === 1'b1) begin
            log_cnt <= 2; bus.log_rdy <= 1'b0; bus.log_out_d <= 16'hzzzz;
        end else if (log_cnt == 2) begin
            log_cnt <= 1;
        end else if (log_cnt == 1) begin
            log_cnt <= 0; bus.log_rdy <= 1'b1;
            bus.log_out_d <= log_fn(bus.op_sub, bus.op_a, bus.op_b);
        end else begin
            bus.log_rdy <= 1'b1; bus.log_out_d <= 16'hzzzz;
        end
    end

    // Arith unit: same handshake timing as the logic unit.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ari_cnt <= 0; bus.ari_rdy <= 1'b1; bus.ari_out_d <= 16'hzzzz;
        end else if (ari_mode == 1) begin
            ari_cnt <= 0; bus.ari_rdy <= 1'b1; bus.ari_out_d <= 16'hzzzz;
        end else if (ari_mode == 2) begin
            ari_cnt <= 0; bus.ari_rdy <= 1'bx; bus.ari_out_d <= 16'hzzzz;
        end else if (bus.ari_cs === 1'b1) begin
            ari_cnt <= 2; bus.ari_rdy <= 1'b0; bus.ari_out_d <= 16'hzzzz;
        end else if (ari_cnt == 2) begin
            ari_cnt <= 1;
        end else if (ari_cnt == 1) begin
            ari_cnt <= 0; bus.ari_rdy <= 1'b1;
            bus.ari_out_d <= ari_fn(bus.op_sub, bus.op_a, bus.op_b);
        end else begin
            bus.ari_rdy <= 1'b1; bus.ari_out_d <= 16'hzzzz;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge; returns 1 ns after that edge (edge N).
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1; bus.opcode = op; bus.a_in = a; bus.b_in = b;
        tick;
        bus.start = 1'b0; bus.a_in = 16'h0000; bus.b_in = 16'h0000; bus.opcode = 4'b0000;
    endtask

    // Run one request, recording the edge index (after N) of done/err and cs counts.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int done_k, output int err_k, output int lcs_n, output int acs_n);
        issue(op, a, b);
        done_k = -1; err_k = -1; lcs_n = 0; acs_n = 0;
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) tick;
            if (bus.log_cs === 1'b1) lcs_n++;
            if (bus.ari_cs === 1'b1) acs_n++;
            if (bus.done === 1'b1 && done_k < 0) done_k = k;
            if (bus.err === 1'b1 && err_k < 0) err_k = k;
            if (done_k >= 0 || err_k >= 0) break;
        end
        tick;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.opcode = 4'b0000; bus.a_in = 16'h0000; bus.b_in = 16'h0000;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_cmp++; if ({bus.log_cs, bus.ari_cs} !== 2'b00) begin n_err++; $display("FAIL reset_cs got %b exp 00", {bus.log_cs, bus.ari_cs}); end
        n_cmp++; if ({bus.done, bus.err, bus.zf} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {bus.done, bus.err, bus.zf}); end
        n_cmp++; if (bus.result !== 16'h0000) begin n_err++; $display("FAIL reset_result got %h exp 0000", bus.result); end
        n_cmp++; if ({bus.op_a, bus.op_b, bus.op_sub} !== 34'h0) begin n_err++; $display("FAIL reset_operands got %h exp 0", {bus.op_a, bus.op_b, bus.op_sub}); end
        tick; tick;
        rst = 1'b0;
        tick;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_nand;
        logic exp_v;
        log_mode = 0; ari_mode = 2;
        issue(4'b0000, 16'hFFFF, 16'h00FF);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick;
            exp_v = (k == 0);
            n_cmp++; if (bus.log_cs !== exp_v) begin n_err++; $display("FAIL nand_log_cs k=%0d got %b exp %b", k, bus.log_cs, exp_v); end
            n_cmp++; if (bus.ari_cs !== 1'b0) begin n_err++; $display("FAIL nand_ari_cs k=%0d got %b exp 0", k, bus.ari_cs); end
            exp_v = (k == 4);
            n_cmp++; if (bus.done !== exp_v) begin n_err++; $display("FAIL nand_done k=%0d got %b exp %b", k, bus.done, exp_v); end
            n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL nand_busy k=%0d got %b exp 1", k, bus.busy); end
            n_cmp++; if ({bus.op_a, bus.op_b, bus.op_sub} !== {16'hFFFF, 16'h00FF, 2'b00}) begin n_err++; $display("FAIL nand_operands k=%0d got %h %h %b", k, bus.op_a, bus.op_b, bus.op_sub); end
        end
        n_cmp++; if (bus.result !== 16'hFF00) begin n_err++; $display("FAIL nand_result got %h exp FF00", bus.result); end
        n_cmp++; if (bus.zf !== 1'b0) begin n_err++; $display("FAIL nand_zf got %b exp 0", bus.zf); end
        tick;
        n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_err++; $display("FAIL nand_after got done/busy %b exp 00", {bus.done, bus.busy}); end
    endtask

    task automatic test_xor_zero;
        int dk, ek, lc, ac;
        log_mode = 0; ari_mode = 2;
        run_op(4'b0010, 16'h1234, 16'h1234, dk, ek, lc, ac);
        n_cmp++; if (dk !== 4 || ek !== -1) begin n_err++; $display("FAIL xor_timing got done_k=%0d err_k=%0d exp 4/-1", dk, ek); end
        n_cmp++; if (lc !== 1 || ac !== 0) begin n_err++; $display("FAIL xor_cs got log=%0d ari=%0d exp 1/0", lc, ac); end
        n_cmp++; if (bus.result !== 16'h0000) begin n_err++; $display("FAIL xor_result got %h exp 0000", bus.result); end
        n_cmp++; if (bus.zf !== 1'b1) begin n_err++; $display("FAIL xor_zf got %b exp 1", bus.zf); end
    endtask

    task automatic test_arith;
        int dk, ek, lc, ac;
        log_mode = 2; ari_mode = 0;
        run_op(4'b0100, 16'h1234, 16'h4321, dk, ek, lc, ac);
        n_cmp++; if (dk !== 4 || lc !== 0 || ac !== 1) begin n_err++; $display("FAIL add_handshake got done_k=%0d log=%0d ari=%0d exp 4/0/1", dk, lc, ac); end
        n_cmp++; if ({bus.result, bus.zf} !== {16'h5555, 1'b0}) begin n_err++; $display("FAIL add_result got %h zf=%b exp 5555 zf=0", bus.result, bus.zf); end
        run_op(4'b0101, 16'h8000, 16'h0001, dk, ek, lc, ac);
        n_cmp++; if (dk !== 4 || ek !== -1) begin n_err++; $display("FAIL sub_timing got done_k=%0d err_k=%0d exp 4/-1", dk, ek); end
        n_cmp++; if ({bus.result, bus.zf} !== {16'h7FFF, 1'b0}) begin n_err++; $display("FAIL sub_result got %h zf=%b exp 7FFF zf=0", bus.result, bus.zf); end
    endtask

    task automatic test_illegal;
        int dk, ek, lc, ac;
        log_mode = 0; ari_mode = 0;
        run_op(4'b1000, 16'hAAAA, 16'h5555, dk, ek, lc, ac);
        n_cmp++; if (ek !== 0 || dk !== -1) begin n_err++; $display("FAIL illegal8_timing got err_k=%0d done_k=%0d exp 0/-1", ek, dk); end
        n_cmp++; if (lc !== 0 || ac !== 0) begin n_err++; $display("FAIL illegal8_cs got log=%0d ari=%0d exp 0/0", lc, ac); end
        n_cmp++; if ({bus.result, bus.zf} !== {16'h7FFF, 1'b0}) begin n_err++; $display("FAIL illegal8_result got %h zf=%b exp 7FFF zf=0", bus.result, bus.zf); end
        n_cmp++; if ({bus.err, bus.busy} !== 2'b00) begin n_err++; $display("FAIL illegal8_after got err/busy %b exp 00", {bus.err, bus.busy}); end
        run_op(4'b1111, 16'h0000, 16'h0000, dk, ek, lc, ac);
        n_cmp++; if (ek !== 0 || lc !== 0 || ac !== 0) begin n_err++; $display("FAIL illegalF got err_k=%0d log=%0d ari=%0d exp 0/0/0", ek, lc, ac); end
    endtask

    task automatic test_timeout;
        int dk, ek, lc, ac;
        log_mode = 1; ari_mode = 2;
        run_op(4'b0011, 16'h00F0, 16'h0F00, dk, ek, lc, ac);
        n_cmp++; if (ek !== 16) begin n_err++; $display("FAIL timeout_err_edge got %0d exp 16", ek); end
        n_cmp++; if (dk !== -1 || lc !== 1) begin n_err++; $display("FAIL timeout_done_cs got done_k=%0d log=%0d exp -1/1", dk, lc); end
        n_cmp++; if ({bus.result, bus.zf} !== {16'h7FFF, 1'b0}) begin n_err++; $display("FAIL timeout_result got %h zf=%b exp 7FFF zf=0", bus.result, bus.zf); end
        n_cmp++; if ({bus.err, bus.busy} !== 2'b00) begin n_err++; $display("FAIL timeout_after got err/busy %b exp 00", {bus.err, bus.busy}); end
        log_mode = 0;
    endtask

    task automatic test_busy;
        log_mode = 0; ari_mode = 2;
        issue(4'b0000, 16'h0F0F, 16'h0F0F);
        tick; tick;
        bus.start = 1'b1; bus.opcode = 4'b1000; bus.a_in = 16'hBEEF; bus.b_in = 16'hBEEF;
        tick;
        bus.start = 1'b0; bus.opcode = 4'b0000;
        n_cmp++; if ({bus.busy, bus.err} !== 2'b10) begin n_err++; $display("FAIL busy_ignore got busy/err %b exp 10", {bus.busy, bus.err}); end
        n_cmp++; if ({bus.op_a, bus.op_sub} !== {16'h0F0F, 2'b00}) begin n_err++; $display("FAIL busy_stable got %h %b exp 0F0F 00", bus.op_a, bus.op_sub); end
        tick;
        n_cmp++; if ({bus.done, bus.result} !== {1'b1, 16'hF0F0}) begin n_err++; $display("FAIL busy_done got done=%b result=%h exp 1 F0F0", bus.done, bus.result); end
        tick; tick;
        n_cmp++; if ({bus.busy, bus.err, bus.done} !== 3'b000) begin n_err++; $display("FAIL busy_not_restarted got %b exp 000", {bus.busy, bus.err, bus.done}); end
    endtask

    task automatic test_back_to_back;
        int dk, ek, lc, ac;
        log_mode = 0; ari_mode = 0;
        run_op(4'b0001, 16'h0FF0, 16'h00FF, dk, ek, lc, ac);
        n_cmp++; if ({bus.result, bus.zf} !== {16'h00F0, 1'b0}) begin n_err++; $display("FAIL b2b_first got %h zf=%b exp 00F0 zf=0", bus.result, bus.zf); end
        run_op(4'b0110, 16'hFFFF, 16'h0000, dk, ek, lc, ac);
        n_cmp++; if (dk !== 4 || ac !== 1) begin n_err++; $display("FAIL b2b_second got done_k=%0d ari=%0d exp 4/1", dk, ac); end
        n_cmp++; if ({bus.result, bus.zf} !== {16'h0000, 1'b1}) begin n_err++; $display("FAIL b2b_second_result got %h zf=%b exp 0000 zf=1", bus.result, bus.zf); end
        run_op(4'b1010, 16'h0000, 16'h0000, dk, ek, lc, ac);
        run_op(4'b0011, 16'h00F0, 16'h0F00, dk, ek, lc, ac);
        n_cmp++; if (dk !== 4 || bus.result !== 16'h0FF0) begin n_err++; $display("FAIL b2b_after_err got done_k=%0d result=%h exp 4 0FF0", dk, bus.result); end
    endtask

    task automatic test_reset_mid;
        int seen;
        log_mode = 0; ari_mode = 2;
        issue(4'b0000, 16'h1111, 16'h2222);
        rst = 1'b1;
        #1;
        n_cmp++; if ({bus.log_cs, bus.busy} !== 2'b00) begin n_err++; $display("FAIL rst_issue got cs/busy %b exp 00", {bus.log_cs, bus.busy}); end
        tick;
        rst = 1'b0;
        issue(4'b0001, 16'hF0F0, 16'hFFFF);
        tick; tick;
        rst = 1'b1;
        #1;
        n_cmp++; if ({bus.busy, bus.log_cs, bus.ari_cs} !== 3'b000) begin n_err++; $display("FAIL rst_wait_done got busy/cs %b exp 000", {bus.busy, bus.log_cs, bus.ari_cs}); end
        n_cmp++; if ({bus.result, bus.op_a} !== {16'h0000, 16'h0000}) begin n_err++; $display("FAIL rst_wait_done_data got %h %h exp 0000 0000", bus.result, bus.op_a); end
        tick; tick;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_no_pulse got %0d active cycles exp 0", seen); end
    endtask

    initial begin
        test_reset;
        test_nand;
        test_xor_zero;
        test_arith;
        test_illegal;
        test_timeout;
        test_busy;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
